// File: rtl/alu_pkg.sv
// Shared types for the ALU sweep controller: the ALU operation enum, the sweep
// FSM states and a reference evaluation of each operation.
package alu_pkg;

  typedef enum logic [2:0] {
    ADD,
    SUB,
    AND,
    OR,
    XOR
  } aluFun_t;

  localparam int NUM_OPS = 5;

  localparam aluFun_t LAST_OP = XOR;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } sweep_state_t;

  // Sweep order follows the declaration order of aluFun_t.
  function automatic aluFun_t next_op(input aluFun_t f);
    case (f)
      ADD:     next_op = SUB;
      SUB:     next_op = AND;
      AND:     next_op = OR;
      OR:      next_op = XOR;
      default: next_op = ADD;
    endcase
  endfunction

  function automatic logic [7:0] alu_eval(input aluFun_t f, input logic [7:0] x,
                                          input logic [7:0] y);
    case (f)
      ADD:     alu_eval = x + y;
      SUB:     alu_eval = x - y;
      AND:     alu_eval = x & y;
      OR:      alu_eval = x | y;
      default: alu_eval = x ^ y;
    endcase
  endfunction

endpackage

// File: rtl/alu_stage.sv
// Registered ALU over aluFun_t with one cycle of latency; result_valid is the
// issuing op_valid delayed by one cycle and the result holds between issues.
module alu_stage
  import alu_pkg::*;
(
  input  logic       clock,
  input  logic       reset_N,
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  aluFun_t    op,
  input  logic       op_valid,
  output logic [7:0] result,
  output logic       result_valid
);

  always_ff @(posedge clock or negedge reset_N) begin
    if (!reset_N) begin
      result       <= 8'h00;
      result_valid <= 1'b0;
    end else begin
      result_valid <= op_valid;
      if (op_valid) begin
        result <= alu_eval(op, a, b);
      end
    end
  end

endmodule

// File: rtl/alu_sweep_ctrl.sv
// Sweeps one operand pair through every ALU operation, collecting each result
// (or 8'hFF on timeout) into a small readable buffer and an XOR checksum.
module alu_sweep_ctrl
  import alu_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic       clock,
  input  logic       reset_N,
  input  logic       start,
  input  logic [7:0] a_in,
  input  logic [7:0] b_in,
  output logic [7:0] a,
  output logic [7:0] b,
  output aluFun_t    op,
  output logic       op_valid,
  input  logic [7:0] result,
  input  logic       result_valid,
  output logic       busy,
  output logic       done,
  output logic [7:0] checksum,
  output logic       err,
  input  logic [2:0] rd_idx,
  output logic [7:0] rd_data
);

  localparam int TW = $clog2(TIMEOUT + 1);

  sweep_state_t state_reg, state_next;
  logic [TW-1:0] timer_reg;
  logic [7:0]    buffer_q [NUM_OPS];

  logic          accept;
  logic          capture;
  logic          expire;
  logic          stray;
  logic          advance;
  logic [7:0]    entry_value;

  always_ff @(posedge clock or negedge reset_N) begin
    if (!reset_N) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    op_valid   = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    accept     = 1'b0;
    capture    = 1'b0;
    expire     = 1'b0;
    stray      = 1'b0;
    case (state_reg)
      IDLE: begin
        stray = result_valid;
        if (start) begin
          accept     = 1'b1;
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        op_valid   = 1'b1;
        busy       = 1'b1;
        stray      = result_valid;
        state_next = WAIT;
      end
      WAIT: begin
        busy = 1'b1;
        // A result arriving on the final timer cycle still counts as valid.
        if (result_valid) begin
          capture = 1'b1;
        end else if (timer_reg == TW'(TIMEOUT - 1)) begin
          expire = 1'b1;
        end
        if (result_valid || (timer_reg == TW'(TIMEOUT - 1))) begin
          state_next = (op == LAST_OP) ? DONE : ISSUE;
        end
      end
      DONE: begin
        done       = 1'b1;
        stray      = result_valid;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign advance     = capture | expire;
  assign entry_value = capture ? result : 8'hFF;

  always_ff @(posedge clock or negedge reset_N) begin
    if (!reset_N) begin
      timer_reg <= '0;
    end else if (state_reg == ISSUE) begin
      timer_reg <= '0;
    end else if ((state_reg == WAIT) && !advance) begin
      timer_reg <= timer_reg + TW'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_N) begin
    if (!reset_N) begin
      a        <= 8'h00;
      b        <= 8'h00;
      op       <= ADD;
      checksum <= 8'h00;
      err      <= 1'b0;
    end else begin
      if (accept) begin
        a        <= a_in;
        b        <= b_in;
        op       <= ADD;
        checksum <= 8'h00;
        err      <= 1'b0;
      end
      if (advance) begin
        checksum <= checksum ^ entry_value;
        if (op != LAST_OP) begin
          op <= next_op(op);
        end
      end
      if (expire || stray) begin
        err <= 1'b1;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_OPS; gi++) begin : g_buf
      logic [7:0] entry_reg;

      always_ff @(posedge clock or negedge reset_N) begin
        if (!reset_N) begin
          entry_reg <= 8'h00;
        end else if (accept) begin
          entry_reg <= 8'h00;
        end else if (advance && (int'(op) == gi)) begin
          entry_reg <= entry_value;
        end
      end

      assign buffer_q[gi] = entry_reg;
    end
  endgenerate

  always_comb begin
    rd_data = 8'h00;
    for (int i = 0; i < NUM_OPS; i++) begin
      if (rd_idx == 3'(i)) begin
        rd_data = buffer_q[i];
      end
    end
  end

endmodule

// File: tb/tb_alu_sweep_ctrl.sv
// Randomized bench for alu_sweep_ctrl driven through alu_stage, with injectable
// dropped, late and unsolicited result_valid pulses and an arithmetic model.
module tb_alu_sweep_ctrl;
  import alu_pkg::*;

  localparam int TO = 7;

  logic       clock = 1'b0;
  logic       reset_N = 1'b0;
  logic       start = 1'b0;
  logic [7:0] a_in = 8'h00;
  logic [7:0] b_in = 8'h00;
  logic [7:0] a, b;
  aluFun_t    op;
  logic       op_valid;
  logic [7:0] result;
  logic       result_valid;
  logic       busy, done, err;
  logic [7:0] checksum;
  logic [2:0] rd_idx = 3'd0;
  logic [7:0] rd_data;

  logic [7:0] alu_res;
  logic       alu_rv;
  logic [4:0] drop_mask = 5'd0;
  logic [4:0] late_mask = 5'd0;
  logic       late_rv = 1'b0;
  logic       inj_rv = 1'b0;
  logic       late_armed = 1'b0;
  int         late_cnt = 0;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  alu_sweep_ctrl #(.TIMEOUT(TO)) dut (
    .clock(clock), .reset_N(reset_N), .start(start), .a_in(a_in), .b_in(b_in),
    .a(a), .b(b), .op(op), .op_valid(op_valid), .result(result),
    .result_valid(result_valid), .busy(busy), .done(done), .checksum(checksum),
    .err(err), .rd_idx(rd_idx), .rd_data(rd_data)
  );

  alu_stage u_alu (
    .clock(clock), .reset_N(reset_N), .a(a), .b(b), .op(op), .op_valid(op_valid),
    .result(alu_res), .result_valid(alu_rv)
  );

  assign result       = alu_res;
  assign result_valid = (alu_rv & ~(drop_mask[op] | late_mask[op])) | late_rv | inj_rv;

  // Late responder: answers a late-masked op exactly on the last timer cycle.
  always @(negedge clock) begin
    late_rv = 1'b0;
    if (late_armed) begin
      if (late_cnt == TO - 1) begin
        late_rv    = 1'b1;
        late_armed = 1'b0;
      end else begin
        late_cnt++;
      end
    end else if (op_valid && late_mask[op]) begin
      late_armed = 1'b1;
      late_cnt   = 0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] ref_alu(input int k, input logic [7:0] x, input logic [7:0] y);
    case (k)
      0:       return x + y;
      1:       return x - y;
      2:       return x & y;
      3:       return x | y;
      default: return x ^ y;
    endcase
  endfunction

  task automatic check_all_zero(input string tag);
    chk({tag, "_a"}, 32'(a), 32'h0);
    chk({tag, "_b"}, 32'(b), 32'h0);
    chk({tag, "_op"}, 32'(op), 32'(ADD));
    chk({tag, "_op_valid"}, 32'(op_valid), 32'h0);
    chk({tag, "_busy"}, 32'(busy), 32'h0);
    chk({tag, "_done"}, 32'(done), 32'h0);
    chk({tag, "_err"}, 32'(err), 32'h0);
    chk({tag, "_checksum"}, 32'(checksum), 32'h0);
    for (int i = 0; i < NUM_OPS; i++) begin
      rd_idx = 3'(i);
      #1;
      chk({tag, "_buf"}, 32'(rd_data), 32'h0);
    end
  endtask

  // One sweep. dm: ops whose result is withheld; lm: ops answered on the last
  // timer cycle; mid: pulse start mid-sweep; abort_cyc>0: reset at that cycle.
  task automatic do_sweep(input logic [7:0] av, input logic [7:0] bv, input logic [4:0] dm,
                          input logic [4:0] lm, input bit mid, input int abort_cyc);
    logic [7:0] ebuf [NUM_OPS];
    logic [7:0] ecs;
    int         exp_lat;
    int         cyc;
    ecs     = 8'h00;
    exp_lat = 1;
    for (int k = 0; k < NUM_OPS; k++) begin
      ebuf[k]  = dm[k] ? 8'hFF : ref_alu(k, av, bv);
      ecs     ^= ebuf[k];
      exp_lat += (dm[k] || lm[k]) ? TO + 1 : 2;
    end
    drop_mask = dm;
    late_mask = lm;

    @(negedge clock);
    a_in  = av;
    b_in  = bv;
    start = 1'b1;
    @(negedge clock);
    cyc   = 1;
    start = 1'b0;
    a_in  = 8'($urandom);
    b_in  = 8'($urandom);
    chk("busy_after_start", 32'(busy), 32'h1);
    chk("first_issue", 32'(op_valid), 32'h1);
    chk("first_op", 32'(op), 32'(ADD));
    chk("latched_a", 32'(a), 32'(av));
    chk("latched_b", 32'(b), 32'(bv));

    while (!done && cyc < 400) begin
      start = (mid && cyc == 4);
      if (start) begin
        a_in = 8'($urandom);
        b_in = 8'($urandom);
      end
      if (cyc == abort_cyc) begin
        chk("abort_op", 32'(op), 32'(AND));
        chk("abort_busy", 32'(busy), 32'h1);
        drop_mask = 5'd0;
        late_mask = 5'd0;
        reset_N   = 1'b0;
        #1;
        check_all_zero("abort_reset");
        @(negedge clock);
        @(negedge clock);
        reset_N = 1'b1;
        for (int i = 0; i < 4; i++) begin
          @(negedge clock);
          chk("abort_no_done", 32'(done), 32'h0);
        end
        return;
      end
      @(negedge clock);
      cyc++;
    end
    start = 1'b0;

    $display("sweep a=%02h b=%02h drop=%05b late=%05b mid=%0d latency=%0d checksum=%02h err=%0d",
             av, bv, dm, lm, mid, cyc, checksum, err);
    chk("latency", 32'(cyc), 32'(exp_lat));
    chk("done_pulse", 32'(done), 32'h1);
    chk("busy_at_done", 32'(busy), 32'h0);
    chk("checksum", 32'(checksum), 32'(ecs));
    chk("err", 32'(err), 32'(|dm));
    @(negedge clock);
    chk("done_one_cycle", 32'(done), 32'h0);
    chk("idle_no_issue", 32'(op_valid), 32'h0);
    for (int i = 0; i < 8; i++) begin
      rd_idx = 3'(i);
      #1;
      chk("rd_data", 32'(rd_data), (i < NUM_OPS) ? 32'(ebuf[i]) : 32'h0);
    end
    drop_mask = 5'd0;
    late_mask = 5'd0;
  endtask

  initial begin
    logic [7:0] av, bv;
    logic [4:0] dm, lm;
    bit         mid;

    #1;
    check_all_zero("reset");
    @(negedge clock);
    @(negedge clock);
    reset_N = 1'b1;

    // Reference vector, then unsolicited result_valid while idle.
    do_sweep(8'h35, 8'h15, 5'b00000, 5'b00000, 1'b0, 0);
    @(negedge clock);
    inj_rv = 1'b1;
    @(negedge clock);
    inj_rv = 1'b0;
    #1;
    chk("idle_rv_err", 32'(err), 32'h1);
    chk("idle_rv_checksum", 32'(checksum), 32'h6A);
    rd_idx = 3'd0;
    #1;
    chk("idle_rv_buf0", 32'(rd_data), 32'h4A);
    rd_idx = 3'd7;
    #1;
    chk("rd_idx7", 32'(rd_data), 32'h00);

    do_sweep(8'h35, 8'h15, 5'b00010, 5'b00000, 1'b0, 0);
    do_sweep(8'h35, 8'h15, 5'b00000, 5'b00000, 1'b1, 0);
    do_sweep(8'h35, 8'h15, 5'b00000, 5'b01000, 1'b0, 0);
    do_sweep(8'h35, 8'h15, 5'b00000, 5'b00000, 1'b0, 6);
    do_sweep(8'h01, 8'h01, 5'b00000, 5'b00000, 1'b0, 0);

    for (int s = 0; s < 10; s++) begin
      av  = 8'($urandom);
      bv  = 8'($urandom);
      dm  = ($urandom_range(0, 2) == 0) ? 5'($urandom) : 5'd0;
      lm  = ($urandom_range(0, 2) == 0) ? (5'($urandom) & ~dm) : 5'd0;
      mid = 1'($urandom_range(0, 1));
      do_sweep(av, bv, dm, lm, mid, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
